// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, command record and strobe levels for the bus cycle arbiter
package bus_pkg;
    localparam int BUS_ADDR_W = 20;
    localparam int BUS_DATA_W = 8;
    localparam logic STROBE_IDLE = 1'b1;
    localparam logic STROBE_ACT = 1'b0;
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_t;
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic iom;
        logic write;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting one past the last winner
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            any_valid
);
    // walk from farthest to nearest so the slot right after ptr ends up winning
    always_comb begin
        win = '0;
        for (int o = NREQ; o >= 1; o--) begin
            if (req[(int'(ptr) + o) % NREQ]) win = NREQ'(1) << ((int'(ptr) + o) % NREQ);
        end
    end
    assign any_valid = |req;
endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin T1..T4 bus cycle engine for an 8086 min-mode local bus.
// Define WAIT_TIMEOUT_EN to abort cycles that sit in wait states for TIMEOUT cycles.
module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]        req_iom,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   err,
    output logic                   ALE,
    output logic                   IOM,
    output logic [ADDR_W-1:0]      Address,
    output logic                   RD,
    output logic                   WR,
    output logic [DATA_W-1:0]      DataOut,
    output logic                   DataOE,
    input  logic [DATA_W-1:0]      DataIn,
    input  logic                   READY
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    bus_state_t state, nxt;
    bus_cmd_t cmd, sel;
    logic [NREQ-1:0] win, owner;
    logic [PW-1:0] ptr, win_idx;
    logic any_valid, timeout, strobe, drive;
    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req(req),
        .ptr(ptr),
        .win(win),
        .any_valid(any_valid)
    );
    always_comb begin
        win_idx = '0;
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                sel = '{addr: req_addr[i*ADDR_W +: ADDR_W], iom: req_iom[i],
                        write: req_write[i], wdata: req_wdata[i*DATA_W +: DATA_W]};
            end
        end
    end
`ifdef WAIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1) > 4 ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] wcnt;
    always_ff @(posedge CLK)
        wcnt <= (RESET || nxt == T3) ? '0 : (state == TW) ? wcnt + 1'b1 : wcnt;
    assign timeout = state == TW && !READY && wcnt == CW'(TIMEOUT - 1);
`else
    // without the watchdog TIMEOUT has no effect and wait states last until READY
    assign timeout = TIMEOUT < 0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any_valid ? T1 : IDLE;
            T1:      nxt = T2;
            T2:      nxt = T3;
            T3, TW:  nxt = (READY || timeout) ? T4 : TW;
            default: nxt = IDLE;
        endcase
    end
    assign strobe = nxt == T2 || nxt == T3 || nxt == TW;
    assign drive = strobe || nxt == T4;
    assign Address = cmd.addr;
    assign IOM = cmd.iom;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            ptr <= PW'(NREQ - 1);
            cmd <= '0;
            owner <= '0;
            gnt <= '0;
            done <= '0;
            err <= 1'b0;
            rdata <= '0;
            ALE <= 1'b0;
            RD <= STROBE_IDLE;
            WR <= STROBE_IDLE;
            DataOut <= '0;
            DataOE <= 1'b0;
        end else begin
            state <= nxt;
            gnt <= nxt == T1 ? win : '0;
            done <= nxt == T4 ? owner : '0;
            err <= nxt == T4 && timeout;
            ALE <= nxt == T1;
            RD <= (strobe && !cmd.write) ? STROBE_ACT : STROBE_IDLE;
            WR <= (strobe && cmd.write) ? STROBE_ACT : STROBE_IDLE;
            DataOE <= drive && cmd.write;
            if (nxt == T1) begin
                cmd <= sel;
                owner <= win;
                ptr <= win_idx;
            end
            if (nxt == T2 && cmd.write) DataOut <= cmd.wdata;
            if ((state == T3 || state == TW) && READY && !cmd.write) rdata <= DataIn;
        end
    end
endmodule
